// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if
//  Bundles the PS/2 pin pair and the status/pulse outputs of ps2_keyboard_rx.
//  Ports of the bundle:
//   ps2_clk    raw PS/2 clock pin (asynchronous to the system clock)
//   ps2_data   raw PS/2 data pin (asynchronous to the system clock)
//   ps2_read   N-bit key status word polled by the CPU via the address decoder
//   byte_valid one-cycle pulse per good received byte (prefixes included)
//   frame_err  one-cycle pulse on parity error, stop-bit error or timeout abort
//  Modports:
//   slave  - the receiver itself (pins in, status out)
//   master - whatever drives the pins and observes the status (board / bench)
interface ps2_keyboard_rx_if #(
  parameter int N = 32
);
  logic         ps2_clk;
  logic         ps2_data;
  logic [N-1:0] ps2_read;
  logic         byte_valid;
  logic         frame_err;

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output ps2_read,
    output byte_valid,
    output frame_err
  );

  modport master (
    output ps2_clk,
    output ps2_data,
    input  ps2_read,
    input  byte_valid,
    input  frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//  Receives device-to-host PS/2 keyboard frames (start, 8 data bits LSB first,
//  odd parity, stop) and decodes scan-code set 2 make / break (F0) / extended
//  (E0) prefixes into a status word the CPU polls at the PS/2 window.
//  Ports:
//   clk    system clock, the only clock of the block
//   rst_n  asynchronous active-low reset
//   bus    ps2_keyboard_rx_if.slave:
//            ps2_clk, ps2_data  raw pins, asynchronous to clk
//            ps2_read[N-1:0]    status word:
//                               [7:0] last key byte, [8] extended, [9] release,
//                               [10] space held, [23:16] event counter,
//                               [24] frame error since last key event
//            byte_valid         pulse per good byte
//            frame_err          pulse per bad or aborted frame
//  Timing: stop-bit falling edge seen in cycle t -> byte_valid/frame_err in
//  t+1 -> ps2_read updated in t+2.
module ps2_keyboard_rx #(
  parameter int N       = 32,
  parameter int TIMEOUT = 10000
) (
  input  logic              clk,
  input  logic              rst_n,
  ps2_keyboard_rx_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] SPACE_CODE   = 8'h29;

  // Pin synchronizers and falling-edge history
  logic syncClk1_q, syncClk2_q, prevClk_q;
  logic syncData1_q, syncData2_q;

  // Frame receiver
  logic [1:0]    state_q, state_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] toCnt_q, toCnt_d;
  logic          byteValid_q, byteValid_d;
  logic          frameErr_q, frameErr_d;
  logic [7:0]    rxByte_q, rxByte_d;

  // Decoder state and status-word fields
  logic       relPend_q, relPend_d;
  logic       extPend_q, extPend_d;
  logic [7:0] readByte_q, readByte_d;
  logic       readExt_q, readExt_d;
  logic       readRel_q, readRel_d;
  logic       readSpace_q, readSpace_d;
  logic [7:0] readCnt_q, readCnt_d;
  logic       readErr_q, readErr_d;

  logic         fe;
  logic         toAbort;
  logic [N-1:0] ps2Read;

  // Two-flop synchronizers for both pins. They reset to 1 so that the idle
  // high line does not look like a falling edge when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncClk1_q  <= 1'b1;
      syncClk2_q  <= 1'b1;
      prevClk_q   <= 1'b1;
      syncData1_q <= 1'b1;
      syncData2_q <= 1'b1;
    end else begin
      syncClk1_q  <= bus.ps2_clk;
      syncClk2_q  <= syncClk1_q;
      prevClk_q   <= syncClk2_q;
      syncData1_q <= bus.ps2_data;
      syncData2_q <= syncData1_q;
    end
  end

  assign fe = prevClk_q & ~syncClk2_q;

  // The abort fires on the edge that ends the (TIMEOUT-1)th quiet cycle so
  // that the frame_err pulse lands exactly TIMEOUT cycles after the last edge,
  // mirroring the one-cycle delay of the stop-bit result.
  assign toAbort = (state_q != IDLE) && !fe && (toCnt_q == CW'(TIMEOUT - 2));

  // Frame receiver: advances only on PS/2 falling edges, apart from the
  // inactivity timeout which returns a stalled partial frame to IDLE.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    rxByte_d    = rxByte_q;
    byteValid_d = 1'b0;
    frameErr_d  = 1'b0;
    toCnt_d     = (state_q == IDLE || fe) ? '0 : toCnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (fe && !syncData2_q) begin
          state_d  = DATA;
          bitCnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fe) begin
          shift_d  = {syncData2_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fe) begin
          parity_d = syncData2_q;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fe) begin
          if (syncData2_q && (^{shift_q, parity_q})) begin
            byteValid_d = 1'b1;
            rxByte_d    = shift_q;
          end else begin
            frameErr_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (toAbort) begin
      state_d    = IDLE;
      frameErr_d = 1'b1;
      toCnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitCnt_q    <= 3'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      toCnt_q     <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      rxByte_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      toCnt_q     <= toCnt_d;
      byteValid_q <= byteValid_d;
      frameErr_q  <= frameErr_d;
      rxByte_q    <= rxByte_d;
    end
  end

  // Scan-code decoder. Prefix bytes only arm their pending flags; any other
  // byte becomes a key event carrying the flags, which then clear. Pending
  // flags deliberately survive errored frames so a glitch between a prefix
  // and its key does not turn a break into a make.
  always_comb begin
    relPend_d   = relPend_q;
    extPend_d   = extPend_q;
    readByte_d  = readByte_q;
    readExt_d   = readExt_q;
    readRel_d   = readRel_q;
    readSpace_d = readSpace_q;
    readCnt_d   = readCnt_q;
    readErr_d   = readErr_q;

    if (byteValid_q) begin
      if (rxByte_q == BREAK_PREFIX) begin
        relPend_d = 1'b1;
      end else if (rxByte_q == EXT_PREFIX) begin
        extPend_d = 1'b1;
      end else begin
        readByte_d = rxByte_q;
        readExt_d  = extPend_q;
        readRel_d  = relPend_q;
        readCnt_d  = readCnt_q + 8'd1;
        readErr_d  = 1'b0;
        if (rxByte_q == SPACE_CODE && !extPend_q) begin
          readSpace_d = ~relPend_q;
        end
        relPend_d = 1'b0;
        extPend_d = 1'b0;
      end
    end

    if (frameErr_q) begin
      readErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relPend_q   <= 1'b0;
      extPend_q   <= 1'b0;
      readByte_q  <= 8'd0;
      readExt_q   <= 1'b0;
      readRel_q   <= 1'b0;
      readSpace_q <= 1'b0;
      readCnt_q   <= 8'd0;
      readErr_q   <= 1'b0;
    end else begin
      relPend_q   <= relPend_d;
      extPend_q   <= extPend_d;
      readByte_q  <= readByte_d;
      readExt_q   <= readExt_d;
      readRel_q   <= readRel_d;
      readSpace_q <= readSpace_d;
      readCnt_q   <= readCnt_d;
      readErr_q   <= readErr_d;
    end
  end

  // Status word assembly; unused bits read as zero.
  always_comb begin
    ps2Read        = '0;
    ps2Read[7:0]   = readByte_q;
    ps2Read[8]     = readExt_q;
    ps2Read[9]     = readRel_q;
    ps2Read[10]    = readSpace_q;
    ps2Read[23:16] = readCnt_q;
    ps2Read[24]    = readErr_q;
  end

  assign bus.ps2_read   = ps2Read;
  assign bus.byte_valid = byteValid_q;
  assign bus.frame_err  = frameErr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx
//  Directed bench for ps2_keyboard_rx. The system clock runs at 2 MHz so a
//  12.5 kHz PS/2 clock is 160 system cycles per bit; bulk traffic uses a much
//  faster PS/2 clock to keep the run short. TIMEOUT is shortened to 400.
module tb_ps2_keyboard_rx;

  localparam int N         = 32;
  localparam int TIMEOUT   = 400;
  localparam int SLOW_HALF = 80;
  localparam int FAST_HALF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #250 clk = ~clk;

  ps2_keyboard_rx_if #(.N(N)) bus ();

  ps2_keyboard_rx #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  int cyc = 0;
  int bvCount = 0;
  int feCount = 0;
  int lastBvCyc = -1;
  int lastFeCyc = -1;
  int lastReadChgCyc = -1;
  logic [N-1:0] prevRead = '0;

  always @(posedge clk) cyc++;

  // Pulse and status-change monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1) begin
      bvCount++;
      lastBvCyc = cyc;
    end
    if (bus.frame_err === 1'b1) begin
      feCount++;
      lastFeCyc = cyc;
    end
    if (bus.ps2_read !== prevRead) begin
      lastReadChgCyc = cyc;
      prevRead = bus.ps2_read;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(3);
  endtask

  // One PS/2 bit: data set while the clock is high, then a falling edge.
  // feCyc is the system-cycle count of the edge just before the fall.
  task automatic sendBit(input logic b, input int half, output int feCyc);
    bus.ps2_data = b;
    waitCycles(half);
    bus.ps2_clk = 1'b0;
    feCyc = cyc;
    waitCycles(half);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input int half, input logic badPar,
                           input logic badStop, output int stopCyc);
    int fc;
    logic p;
    p = (~^b) ^ badPar;
    sendBit(1'b0, half, fc);
    for (int i = 0; i < 8; i++) sendBit(b[i], half, fc);
    sendBit(p, half, fc);
    sendBit(~badStop, half, stopCyc);
    bus.ps2_data = 1'b1;
    waitCycles(10);
  endtask

  task automatic sendKey(input logic [7:0] b);
    int sc;
    sendFrame(b, FAST_HALF, 1'b0, 1'b0, sc);
  endtask

  task automatic test_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n = 1'b0;
    waitCycles(4);
    compared++;
    if (bus.ps2_read !== 32'h0 || bus.byte_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got read=%h bv=%b fe=%b expected 0/0/0",
               bus.ps2_read, bus.byte_valid, bus.frame_err);
    end
    rst_n = 1'b1;
    waitCycles(5);
    compared++;
    if (bus.ps2_read !== 32'h0 || bvCount != 0 || feCount != 0) begin
      mismatched++;
      $display("[TB] FAIL reset_release: got read=%h bv=%0d fe=%0d expected 0/0/0",
               bus.ps2_read, bvCount, feCount);
    end
  endtask

  task automatic test_single_frame();
    int sc, b0, f0;
    applyReset();
    b0 = bvCount;
    f0 = feCount;
    sendFrame(8'h1C, SLOW_HALF, 1'b0, 1'b0, sc);
    compared++;
    if (bus.ps2_read !== 32'h0001001C) begin
      mismatched++;
      $display("[TB] FAIL single_read: got %h expected 0001001c", bus.ps2_read);
    end
    compared++;
    if (bvCount - b0 != 1 || feCount != f0) begin
      mismatched++;
      $display("[TB] FAIL single_pulses: got bv=%0d fe=%0d expected 1/0", bvCount - b0, feCount - f0);
    end
    compared++;
    if (lastBvCyc != sc + 3) begin
      mismatched++;
      $display("[TB] FAIL single_bv_latency: got cycle %0d expected %0d", lastBvCyc, sc + 3);
    end
    compared++;
    if (lastReadChgCyc != sc + 4) begin
      mismatched++;
      $display("[TB] FAIL single_read_latency: got cycle %0d expected %0d", lastReadChgCyc, sc + 4);
    end
  endtask

  task automatic test_space_make_break();
    applyReset();
    sendKey(8'h29);
    compared++;
    if (bus.ps2_read !== 32'h00010429) begin
      mismatched++;
      $display("[TB] FAIL space_make: got %h expected 00010429", bus.ps2_read);
    end
    sendKey(8'hF0);
    compared++;
    if (bus.ps2_read !== 32'h00010429) begin
      mismatched++;
      $display("[TB] FAIL prefix_no_update: got %h expected 00010429", bus.ps2_read);
    end
    sendKey(8'h29);
    compared++;
    if (bus.ps2_read !== 32'h00020229) begin
      mismatched++;
      $display("[TB] FAIL space_break: got %h expected 00020229", bus.ps2_read);
    end
  endtask

  task automatic test_extended();
    applyReset();
    sendKey(8'h29);
    sendKey(8'hE0);
    sendKey(8'h75);
    compared++;
    if (bus.ps2_read !== 32'h00020575) begin
      mismatched++;
      $display("[TB] FAIL ext_make: got %h expected 00020575", bus.ps2_read);
    end
    sendKey(8'hE0);
    sendKey(8'hF0);
    sendKey(8'h75);
    compared++;
    if (bus.ps2_read !== 32'h00030775) begin
      mismatched++;
      $display("[TB] FAIL ext_break_e0f0: got %h expected 00030775", bus.ps2_read);
    end
    sendKey(8'hF0);
    sendKey(8'hE0);
    sendKey(8'h75);
    compared++;
    if (bus.ps2_read !== 32'h00040775) begin
      mismatched++;
      $display("[TB] FAIL ext_break_f0e0: got %h expected 00040775", bus.ps2_read);
    end
    sendKey(8'hE0);
    sendKey(8'h29);
    compared++;
    if (bus.ps2_read !== 32'h00050529) begin
      mismatched++;
      $display("[TB] FAIL ext_29_space_kept: got %h expected 00050529", bus.ps2_read);
    end
  endtask

  task automatic test_frame_errors();
    int sc, b0, f0;
    b0 = bvCount;
    f0 = feCount;
    sendFrame(8'h1C, FAST_HALF, 1'b1, 1'b0, sc);
    compared++;
    if (bvCount != b0 || feCount - f0 != 1 || lastFeCyc != sc + 3) begin
      mismatched++;
      $display("[TB] FAIL parity_err_pulse: got bv=%0d fe=%0d at %0d expected 0/1 at %0d",
               bvCount - b0, feCount - f0, lastFeCyc, sc + 3);
    end
    compared++;
    if (bus.ps2_read !== 32'h01050529) begin
      mismatched++;
      $display("[TB] FAIL parity_err_read: got %h expected 01050529", bus.ps2_read);
    end
    sendKey(8'h1C);
    compared++;
    if (bus.ps2_read !== 32'h0006041C) begin
      mismatched++;
      $display("[TB] FAIL err_cleared: got %h expected 0006041c", bus.ps2_read);
    end
    sendKey(8'hF0);
    f0 = feCount;
    sendFrame(8'h1C, FAST_HALF, 1'b0, 1'b1, sc);
    compared++;
    if (feCount - f0 != 1 || bus.ps2_read !== 32'h0106041C) begin
      mismatched++;
      $display("[TB] FAIL stop_err: got fe=%0d read=%h expected 1 and 0106041c",
               feCount - f0, bus.ps2_read);
    end
    sendKey(8'h1C);
    compared++;
    if (bus.ps2_read !== 32'h0007061C) begin
      mismatched++;
      $display("[TB] FAIL prefix_survives_err: got %h expected 0007061c", bus.ps2_read);
    end
  endtask

  task automatic test_timeout();
    int fc, b0, f0;
    logic [7:0] b;
    b = 8'h1C;
    applyReset();
    b0 = bvCount;
    f0 = feCount;
    sendBit(1'b0, FAST_HALF, fc);
    for (int i = 0; i < 4; i++) sendBit(b[i], FAST_HALF, fc);
    bus.ps2_data = 1'b1;
    waitCycles(TIMEOUT + 10);
    compared++;
    if (feCount - f0 != 1 || lastFeCyc != fc + 2 + TIMEOUT) begin
      mismatched++;
      $display("[TB] FAIL timeout_pulse: got %0d pulses at %0d expected 1 at %0d",
               feCount - f0, lastFeCyc, fc + 2 + TIMEOUT);
    end
    compared++;
    if (bus.ps2_read !== 32'h01000000 || bvCount != b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_read: got %h bv=%0d expected 01000000 bv=0",
               bus.ps2_read, bvCount - b0);
    end
    f0 = feCount;
    sendBit(1'b1, FAST_HALF, fc);
    waitCycles(TIMEOUT + 10);
    compared++;
    if (feCount != f0 || bvCount != b0) begin
      mismatched++;
      $display("[TB] FAIL idle_high_edge: got fe=%0d bv=%0d expected 0/0", feCount - f0, bvCount - b0);
    end
    sendKey(8'h1C);
    compared++;
    if (bus.ps2_read !== 32'h0001001C) begin
      mismatched++;
      $display("[TB] FAIL after_timeout: got %h expected 0001001c", bus.ps2_read);
    end
  endtask

  task automatic test_wrap_and_midframe_reset();
    int fc, b0, f0;
    applyReset();
    for (int i = 0; i < 255; i++) sendKey(8'h1C);
    compared++;
    if (bus.ps2_read !== 32'h00FF001C) begin
      mismatched++;
      $display("[TB] FAIL cnt_ff: got %h expected 00ff001c", bus.ps2_read);
    end
    sendKey(8'h1C);
    compared++;
    if (bus.ps2_read !== 32'h0000001C) begin
      mismatched++;
      $display("[TB] FAIL cnt_wrap: got %h expected 0000001c", bus.ps2_read);
    end
    sendKey(8'hF0);
    sendBit(1'b0, FAST_HALF, fc);
    for (int i = 0; i < 3; i++) sendBit(1'b1, FAST_HALF, fc);
    b0 = bvCount;
    f0 = feCount;
    rst_n = 1'b0;
    waitCycles(2);
    compared++;
    if (bus.ps2_read !== 32'h0 || bus.byte_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midframe_reset: got read=%h bv=%b fe=%b expected 0/0/0",
               bus.ps2_read, bus.byte_valid, bus.frame_err);
    end
    bus.ps2_data = 1'b1;
    rst_n = 1'b1;
    waitCycles(3);
    sendKey(8'h1C);
    compared++;
    if (bus.ps2_read !== 32'h0001001C || bvCount - b0 != 1 || feCount != f0) begin
      mismatched++;
      $display("[TB] FAIL after_reset_frame: got %h bv=%0d fe=%0d expected 0001001c 1/0",
               bus.ps2_read, bvCount - b0, feCount - f0);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_space_make_break();
    test_extended();
    test_frame_errors();
    test_timeout();
    test_wrap_and_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #(64'd200000 * 64'd500);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
